uart_debug_bridge: RTL and testbench

Initiator-side companion to the UART peripheral: consumes bytes from a UART receiver, decodes a fixed command frame, and issues single 32-bit read or write transactions on the codebase's standard write/read register interface. A status byte, plus read data for reads, is returned through a UART transmitter byte stream. Sits between a host-facing UART PHY pair and the system bus, giving an external host debug access to any memory-mapped register, including another UART's.

---
 rtl/uart_bridge_pkg.sv | 23 ++
 rtl/uart_bridge_timer.sv | 40 ++++
 rtl/uart_debug_bridge.sv | 175 +++++++++++++++++
 tb/tb_uart_debug_bridge.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART debug bridge.
//   uart_bridge_state_t : bridge FSM state encoding
//   BRIDGE_CMD_*        : frame command bytes
//   BRIDGE_*            : response status byte values
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP_STATUS,
    ST_RESP_DATA
  } uart_bridge_state_t;

  localparam logic [7:0] BRIDGE_CMD_WRITE = 8'h57;
  localparam logic [7:0] BRIDGE_CMD_READ  = 8'h52;

  localparam logic [7:0] BRIDGE_OK        = 8'h00;
  localparam logic [7:0] BRIDGE_BUS_ERROR = 8'h01;
  localparam logic [7:0] BRIDGE_TIMEOUT   = 8'h02;

endpackage

// File: rtl/uart_bridge_timer.sv
// Down-counting timeout timer.
//   clk_i, rst_i : clock, async active-high reset
//   start        : (re)arm the timer; wins over clear
//   clear        : stop the timer
//   expired      : high in the LIMIT-th cycle after the start edge, and stays
//                  high until cleared or restarted
module uart_bridge_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt;
  logic         run;

  // Loaded with LIMIT-1 so the terminal count lands on the LIMIT-th cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      cnt <= W'(LIMIT - 1);
      run <= 1'b1;
    end else if (clear) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (run && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = run && (cnt == '0);

endmodule

// File: rtl/uart_debug_bridge.sv
// UART-to-register-bus debug bridge. Decodes 0x57 (write, 9 bytes) and
// 0x52 (read, 5 bytes) frames from the rx byte stream, issues one 32-bit bus
// transaction, and answers with a status byte (plus 4 LE data bytes on read).
//   clk_i, rst_i                     : clock, async active-high reset
//   rx_valid_i, rx_data_i            : received byte strobe and data
//   tx_valid_o, tx_data_o, tx_ready_i: response byte stream (valid/ready)
//   write_o, write_address_o, write_data_o, write_done_i, write_error_i
//   read_o, read_address_o, read_data_i, read_done_i, read_error_i
//   busy_o                           : high whenever the FSM is not idle
module uart_debug_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned FRAME_TIMEOUT = 1_000_000,
  parameter int unsigned BUS_TIMEOUT   = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        write_o,
  output logic [31:0] write_address_o,
  output logic [31:0] write_data_o,
  input  logic        write_done_i,
  input  logic        write_error_i,
  output logic        read_o,
  output logic [31:0] read_address_o,
  input  logic [31:0] read_data_i,
  input  logic        read_done_i,
  input  logic        read_error_i,
  output logic        busy_o
);

  uart_bridge_state_t state;
  logic        is_write;
  logic [1:0]  idx;
  logic [31:0] addr, wdata, rdata;

  logic cmd_ok, in_frame, frame_start, frame_expired;
  logic bus_start, bus_expired, done, err;

  assign cmd_ok   = (rx_data_i == BRIDGE_CMD_WRITE) || (rx_data_i == BRIDGE_CMD_READ);
  assign in_frame = (state == ST_ADDR) || (state == ST_DATA);

  // Frame timer rearms on the command byte and on every frame byte.
  assign frame_start = rx_valid_i && (in_frame || (state == ST_IDLE && cmd_ok));
  // Bus timer arms on the edge that enters BUS.
  assign bus_start   = rx_valid_i && (idx == 2'd3) &&
                       ((state == ST_ADDR && !is_write) || state == ST_DATA);

  assign done = is_write ? write_done_i  : read_done_i;
  assign err  = is_write ? write_error_i : read_error_i;

  uart_bridge_timer #(.LIMIT(FRAME_TIMEOUT)) u_frame_tmr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start   (frame_start),
    .clear   (!in_frame),
    .expired (frame_expired)
  );

  uart_bridge_timer #(.LIMIT(BUS_TIMEOUT)) u_bus_tmr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start   (bus_start),
    .clear   (state != ST_BUS),
    .expired (bus_expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      is_write   <= 1'b0;
      idx        <= 2'd0;
      addr       <= '0;
      wdata      <= '0;
      rdata      <= '0;
      write_o    <= 1'b0;
      read_o     <= 1'b0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_valid_i && cmd_ok) begin
            is_write <= (rx_data_i == BRIDGE_CMD_WRITE);
            idx      <= 2'd0;
            state    <= ST_ADDR;
          end
        end
        // Bytes shift in from the top so 4 bytes land little-endian.
        ST_ADDR: begin
          if (rx_valid_i) begin
            addr <= {rx_data_i, addr[31:8]};
            idx  <= idx + 2'd1;
            if (idx == 2'd3) begin
              if (is_write) begin
                state <= ST_DATA;
              end else begin
                state  <= ST_BUS;
                read_o <= 1'b1;
              end
            end
          end else if (frame_expired) begin
            state <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (rx_valid_i) begin
            wdata <= {rx_data_i, wdata[31:8]};
            idx   <= idx + 2'd1;
            if (idx == 2'd3) begin
              state   <= ST_BUS;
              write_o <= 1'b1;
            end
          end else if (frame_expired) begin
            state <= ST_IDLE;
          end
        end
        // Done is checked before the timeout so a coincident done wins.
        ST_BUS: begin
          if (done) begin
            write_o    <= 1'b0;
            read_o     <= 1'b0;
            tx_valid_o <= 1'b1;
            tx_data_o  <= err ? BRIDGE_BUS_ERROR : BRIDGE_OK;
            rdata      <= (err || is_write) ? 32'h0 : read_data_i;
            state      <= ST_RESP_STATUS;
          end else if (bus_expired) begin
            write_o    <= 1'b0;
            read_o     <= 1'b0;
            tx_valid_o <= 1'b1;
            tx_data_o  <= BRIDGE_TIMEOUT;
            rdata      <= 32'h0;
            state      <= ST_RESP_STATUS;
          end
        end
        ST_RESP_STATUS: begin
          if (tx_ready_i) begin
            if (is_write) begin
              tx_valid_o <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              tx_data_o <= rdata[7:0];
              rdata     <= {8'h00, rdata[31:8]};
              idx       <= 2'd0;
              state     <= ST_RESP_DATA;
            end
          end
        end
        ST_RESP_DATA: begin
          if (tx_ready_i) begin
            if (idx == 2'd3) begin
              tx_valid_o <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              idx       <= idx + 2'd1;
              tx_data_o <= rdata[7:0];
              rdata     <= {8'h00, rdata[31:8]};
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign write_address_o = addr;
  assign read_address_o  = addr;
  assign write_data_o    = wdata;
  assign busy_o          = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_debug_bridge.sv
module tb_uart_debug_bridge;

  localparam int FT = 100;
  localparam int BT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready = 1'b0;
  logic        write_o, read_o, busy_o;
  logic [31:0] write_address_o, write_data_o, read_address_o;
  logic        write_done = 1'b0, write_error = 1'b0;
  logic        read_done = 1'b0, read_error = 1'b0;
  logic [31:0] read_data = '0;

  always #5 clk = ~clk;

  uart_debug_bridge #(.FRAME_TIMEOUT(FT), .BUS_TIMEOUT(BT)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .rx_valid_i      (rx_valid),
    .rx_data_i       (rx_data),
    .tx_valid_o      (tx_valid_o),
    .tx_data_o       (tx_data_o),
    .tx_ready_i      (tx_ready),
    .write_o         (write_o),
    .write_address_o (write_address_o),
    .write_data_o    (write_data_o),
    .write_done_i    (write_done),
    .write_error_i   (write_error),
    .read_o          (read_o),
    .read_address_o  (read_address_o),
    .read_data_i     (read_data),
    .read_done_i     (read_done),
    .read_error_i    (read_error),
    .busy_o          (busy_o)
  );

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // ---------------- bus responder / request recorder ----------------
  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    int          len;
    bit          stable;
  } req_t;

  req_t        reqq[$];
  req_t        cur;
  int          req_len = 0;
  int          rsp_lat = 0;
  bit          rsp_err = 0;
  bit          rsp_never = 0;
  logic [31:0] rsp_data = '0;

  always @(negedge clk) begin
    bit hit;
    if (write_o || read_o) begin
      if (req_len == 0) begin
        cur.w = write_o;
        cur.a = write_o ? write_address_o : read_address_o;
        cur.d = write_data_o;
        cur.stable = 1;
      end else if (write_o != cur.w ||
                   (write_o ? write_address_o : read_address_o) != cur.a ||
                   (write_o && write_data_o != cur.d)) begin
        cur.stable = 0;
      end
      req_len++;
      hit = !rsp_never && (req_len - 1 == rsp_lat);
      write_done  = hit && write_o;
      read_done   = hit && read_o;
      write_error = hit ? rsp_err : 1'($urandom_range(0, 1));
      read_error  = hit ? rsp_err : 1'($urandom_range(0, 1));
      read_data   = hit ? rsp_data : $urandom;
    end else begin
      if (req_len != 0) begin
        cur.len = req_len;
        reqq.push_back(cur);
      end
      req_len     = 0;
      write_done  = 0;
      read_done   = 0;
      write_error = 0;
      read_error  = 0;
    end
  end

  // ---------------- tx ready driver and byte monitor ----------------
  int rdy_mode = 0;  // 0 always ready, 1 random, 2 stall 5 cycles per byte
  int stall = 0;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = 1'($urandom_range(0, 1));
      default: begin
        if (tx_valid_o) begin
          if (stall < 5) begin tx_ready = 1'b0; stall++; end
          else begin tx_ready = 1'b1; stall = 0; end
        end else begin
          tx_ready = 1'b0;
          stall = 0;
        end
      end
    endcase
  end

  logic [7:0] txq[$];
  bit         prev_hold = 0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    if (prev_hold && !rst) begin
      chk("tx_hold_valid", 32'(tx_valid_o), 32'd1);
      chk("tx_hold_data", 32'(tx_data_o), 32'(prev_data));
    end
    if (tx_valid_o && tx_ready) txq.push_back(tx_data_o);
    prev_hold = tx_valid_o && !tx_ready;
    prev_data = tx_data_o;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = $urandom;
  endtask

  task automatic send_frame(input bit w, input logic [31:0] a, input logic [31:0] d, input bit gaps);
    logic [31:0] t;
    send_byte(w ? 8'h57 : 8'h52);
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(t[7:0]);
      t = t >> 8;
    end
    if (w) begin
      t = d;
      for (int i = 0; i < 4; i++) begin
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        send_byte(t[7:0]);
        t = t >> 8;
      end
    end
  endtask

  // One complete transaction checked against the protocol-level model.
  task automatic run_frame(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input int lat, input bit err, input bit never,
                           input logic [31:0] rd, input bit inject);
    logic [7:0]  exp_tx[$];
    logic [7:0]  status;
    logic [31:0] t;
    int          n;
    rsp_lat = lat; rsp_err = err; rsp_never = never; rsp_data = rd;
    txq.delete();
    reqq.delete();
    status = never ? 8'h02 : (err ? 8'h01 : 8'h00);
    exp_tx.push_back(status);
    if (!w) begin
      t = (never || err) ? 32'h0 : rd;
      for (int i = 0; i < 4; i++) begin
        exp_tx.push_back(t[7:0]);
        t = t >> 8;
      end
    end
    send_frame(w, a, d, 1'b1);
    if (inject) begin
      n = 0;
      while (!(tx_valid_o && txq.size() >= 1) && n < 2000) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      send_byte(8'h57);
    end
    n = 0;
    while (txq.size() < exp_tx.size() && n < 3000) begin
      @(posedge clk); #3;
      n++;
    end
    @(posedge clk); #3;
    chk("idle_after_resp", 32'(busy_o), 32'd0);
    chk("txv_after_resp", 32'(tx_valid_o), 32'd0);
    chk("tx_count", 32'(txq.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < txq.size(); i++)
      chk($sformatf("tx_byte%0d", i), 32'(txq[i]), 32'(exp_tx[i]));
    chk("req_count", 32'(reqq.size()), 32'd1);
    if (reqq.size() > 0) begin
      chk("req_kind", 32'(reqq[0].w), 32'(w));
      chk("req_addr", reqq[0].a, a);
      if (w) chk("req_wdata", reqq[0].d, d);
      chk("req_len", 32'(reqq[0].len), never ? 32'(BT) : 32'(lat + 1));
      chk("req_stable", 32'(reqq[0].stable), 32'd1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int pick;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_txv", 32'(tx_valid_o), 32'd0);
    chk("rst_txd", 32'(tx_data_o), 32'd0);
    chk("rst_write", 32'(write_o), 32'd0);
    chk("rst_read", 32'(read_o), 32'd0);
    chk("rst_waddr", write_address_o, 32'd0);
    chk("rst_wdata", write_data_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    run_frame(1'b0, 32'h8000_0004, 32'h0, 1, 1'b0, 1'b0, 32'h1234_5678, 1'b0);
    run_frame(1'b0, 32'h0000_0C00, 32'h0, 2, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0);
    run_frame(1'b1, 32'h0000_0100, 32'h55AA_55AA, 0, 1'b0, 1'b1, 32'h0, 1'b0);
    // done in the very cycle the bus timeout expires: done wins
    run_frame(1'b0, 32'hA5A5_0000, 32'h0, BT - 1, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b0);

    // unknown command then a partial frame abandoned by the frame timeout
    txq.delete();
    reqq.delete();
    send_byte(8'h41);
    chk("bad_cmd_idle", 32'(busy_o), 32'd0);
    send_byte(8'h57);
    send_byte(8'h10);
    chk("partial_busy", 32'(busy_o), 32'd1);
    repeat (FT - 2) @(negedge clk);
    chk("ftmo_not_yet", 32'(busy_o), 32'd1);
    repeat (2) @(negedge clk);
    chk("ftmo_idle", 32'(busy_o), 32'd0);
    repeat (40) @(negedge clk);
    chk("ftmo_no_tx", 32'(txq.size()), 32'd0);
    chk("ftmo_no_req", 32'(reqq.size()), 32'd0);
    run_frame(1'b1, 32'h0000_0020, 32'h0102_0304, 1, 1'b0, 1'b0, 32'h0, 1'b0);

    // stalled response with a byte injected mid-response
    rdy_mode = 2;
    run_frame(1'b0, 32'h4000_0008, 32'h0, 0, 1'b0, 1'b0, 32'h89AB_CDEF, 1'b1);

    // randomized transactions
    for (int k = 0; k < 24; k++) begin
      rdy_mode = $urandom_range(0, 1);
      pick = $urandom_range(0, 5);
      run_frame(1'($urandom_range(0, 1)), $urandom, $urandom,
                (pick == 4) ? BT - 1 : (pick > 4 ? 0 : pick),
                ($urandom_range(0, 3) == 0), (pick == 5), $urandom, 1'b0);
    end

    // reset while a read request is outstanding
    rdy_mode = 0;
    rsp_never = 1;
    txq.delete();
    send_frame(1'b0, 32'h7777_0000, 32'h0, 1'b0);
    @(posedge clk); #3;
    chk("bus_read_hi", 32'(read_o), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_read_lo", 32'(read_o), 32'd0);
    chk("async_busy_lo", 32'(busy_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (BT + 5) @(negedge clk);
    chk("post_rst_busy", 32'(busy_o), 32'd0);
    chk("post_rst_no_tx", 32'(txq.size()), 32'd0);
    chk("post_rst_read", 32'(read_o), 32'd0);
    run_frame(1'b0, 32'h0000_0044, 32'h0, 0, 1'b0, 1'b0, 32'h600D_CAFE, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
